// File: rtl/led_frame_serializer.sv
// led_frame_serializer: streams an APA102-style frame (start word, LED words, end words)
// MSB-first on a two-wire sclk/sdo link with a programmable serial clock half-period.
module led_frame_serializer #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  led_num,
    input  logic [9:0]  bit_total,
    input  logic        bit_total_valid,
    input  logic        start,
    output logic        pix_req,
    output logic [4:0]  pix_addr,
    input  logic [23:0] pix_data,
    input  logic [4:0]  pix_bright,
    output logic        sclk,
    output logic        sdo,
    output logic        busy,
    output logic        frame_done
);
    typedef enum logic [2:0] {IDLE, LOAD, LATCH, SHIFT, FINISH} state_t;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [4:0]  frames_q, frames_d, nled_q, nled_d, f_q, f_d, bit_q, bit_d, addr_q, addr_d;
    logic [7:0]  div_q, div_d;
    logic [31:0] sh_q, sh_d;
    logic        sclk_q, sclk_d, sdo_q, sdo_d, busy_q, busy_d, done_q, done_d, req_q, req_d;
    logic        led_now;
    logic        unused_bits;

    assign unused_bits = ^bit_total[4:0];
    assign led_now     = f_q != 5'd0 && f_q <= nled_q;

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        nled_d   = nled_q;
        f_d      = f_q;
        bit_d    = bit_q;
        div_d    = div_q;
        sh_d     = sh_q;
        sclk_d   = 1'b0;
        sdo_d    = sdo_q;
        unique case (state_q)
            IDLE: begin
                if (start && bit_total_valid) begin
                    frames_d = bit_total[9:5];
                    nled_d   = led_num;
                    f_d      = 5'd0;
                    state_d  = bit_total[9:5] == 5'd0 ? FINISH : LOAD;
                end
            end
            LOAD:  state_d = LATCH;
            LATCH: begin
                sh_d    = led_now ? {3'b111, pix_bright, pix_data} : {32{f_q != 5'd0}};
                sdo_d   = sh_d[31];
                div_d   = 8'd0;
                bit_d   = 5'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sclk_d = sclk_q;
                div_d  = div_q + 8'd1;
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    // end of the high phase closes the current bit
                    if (sclk_q) begin
                        if (bit_q == 5'd31) begin
                            f_d     = f_q + 5'd1;
                            state_d = f_q == frames_q - 5'd1 ? FINISH : LOAD;
                        end else begin
                            bit_d = bit_q + 5'd1;
                            sh_d  = {sh_q[30:0], 1'b0};
                            sdo_d = sh_q[30];
                        end
                    end
                end
            end
            FINISH: state_d = IDLE;
        endcase
        if (state_d == FINISH) sdo_d = 1'b0;
        req_d  = state_d == LOAD && f_d != 5'd0 && f_d <= nled_d;
        addr_d = req_d ? f_d - 5'd1 : 5'd0;
        busy_d = state_d != IDLE;
        done_d = state_d == FINISH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            frames_q <= 5'd0;
            nled_q   <= 5'd0;
            f_q      <= 5'd0;
            bit_q    <= 5'd0;
            addr_q   <= 5'd0;
            div_q    <= 8'd0;
            sh_q     <= 32'd0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
            nled_q   <= nled_d;
            f_q      <= f_d;
            bit_q    <= bit_d;
            addr_q   <= addr_d;
            div_q    <= div_d;
            sh_q     <= sh_d;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            req_q    <= req_d;
        end
    end

    assign pix_req    = req_q;
    assign pix_addr   = addr_q;
    assign sclk       = sclk_q;
    assign sdo        = sdo_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_led_frame_serializer.sv
// tb_led_frame_serializer: directed runs on two instances (CLK_DIV=2 and 1) checked every
// cycle against a waveform derived from frame/bit arithmetic, plus decoded-word literals.
module tb_led_frame_serializer;
    logic        clk = 1'b0;
    logic        rst_n, bit_total_valid, start;
    logic [4:0]  led_num, pix_bright;
    logic [9:0]  bit_total;
    logic [23:0] pix_data;
    int          sel, mode;

    logic        st0, st1, pr0, pr1, sc0, sc1, sd0, sd1, bz0, bz1, dn0, dn1;
    logic [4:0]  pa0, pa1;
    logic        pix_req, sclk, sdo, busy, frame_done;
    logic [4:0]  pix_addr;

    always #5 clk = ~clk;

    assign st0 = start && sel == 0;
    assign st1 = start && sel == 1;

    led_frame_serializer #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .led_num(led_num), .bit_total(bit_total),
        .bit_total_valid(bit_total_valid), .start(st0), .pix_req(pr0), .pix_addr(pa0),
        .pix_data(pix_data), .pix_bright(pix_bright), .sclk(sc0), .sdo(sd0), .busy(bz0),
        .frame_done(dn0));

    led_frame_serializer #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .led_num(led_num), .bit_total(bit_total),
        .bit_total_valid(bit_total_valid), .start(st1), .pix_req(pr1), .pix_addr(pa1),
        .pix_data(pix_data), .pix_bright(pix_bright), .sclk(sc1), .sdo(sd1), .busy(bz1),
        .frame_done(dn1));

    assign pix_req    = sel == 1 ? pr1 : pr0;
    assign pix_addr   = sel == 1 ? pa1 : pa0;
    assign sclk       = sel == 1 ? sc1 : sc0;
    assign sdo        = sel == 1 ? sd1 : sd0;
    assign busy       = sel == 1 ? bz1 : bz0;
    assign frame_done = sel == 1 ? dn1 : dn0;

    function automatic logic [23:0] pixfn(input logic [4:0] a);
        return mode == 0 ? 24'h123456 : 24'(32'h111111 * (int'(a) + 1));
    endfunction

    // pixel store: answers a read strobe on the following cycle
    always @(posedge clk) if (pix_req) pix_data <= pixfn(pix_addr);

    int          tests, fails, t, tend, edges, nb, preq, dones, done_t;
    bit          active;
    logic        sclk_p;
    logic [31:0] sh;
    logic [31:0] words[$];
    logic [4:0]  addrs[$];

    function automatic logic [31:0] word(input int k);
        if (k == 0) return 32'h0;
        if (k <= int'(led_num)) return {3'b111, pix_bright, pixfn(5'(k - 1))};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [9:0] expv(input int tc);
        int cd, p, k, off, bi, wi;
        logic b, d, s, o, r;
        logic [4:0] a;
        logic [31:0] w;
        cd = sel == 1 ? 1 : 2;
        p  = 2 + 64 * cd;
        {b, d, s, o, r, a} = 10'd0;
        if (tc < tend) begin
            k   = (tc - 1) / p;
            off = (tc - 1) % p;
            b   = 1'b1;
            if (off == 0 && k >= 1 && k <= int'(led_num)) begin
                r = 1'b1;
                a = 5'(k - 1);
            end
            if (off < 2) begin
                w = word(k - 1);
                o = k == 0 ? 1'b0 : w[0];
            end else begin
                bi = (off - 2) / (2 * cd);
                wi = (off - 2) % (2 * cd);
                s  = wi >= cd;
                w  = word(k);
                o  = w[31 - bi];
            end
        end else if (tc == tend) begin
            b = 1'b1;
            d = 1'b1;
        end
        return {b, d, s, o, r, a};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        logic [9:0] ex, ac;
        forever begin
            @(negedge clk);
            if (sclk && !sclk_p) begin
                edges++;
                sh = {sh[30:0], sdo};
                nb++;
                if (nb == 32) begin
                    words.push_back(sh);
                    nb = 0;
                end
            end
            sclk_p = sclk;
            if (active) begin
                t++;
                if (frame_done) begin
                    dones++;
                    done_t = t;
                end
                if (pix_req) begin
                    preq++;
                    addrs.push_back(pix_addr);
                end
                ex = expv(t);
                ac = {busy, frame_done, sclk, sdo, pix_req, pix_req ? pix_addr : 5'd0};
                tests++;
                if (ac !== ex) begin
                    fails++;
                    if (fails < 40) $display("FAIL cycle t=%0d {busy,done,sclk,sdo,req,addr}: got %b expected %b", t, ac, ex);
                end
                if (t == tend + 1) active = 1'b0;
            end
        end
    endtask

    task automatic run(input int s, input int nl, input int bt, input logic [4:0] br,
                       input int md, input bit inject, input int rst_at);
        sel = s;
        mode = md;
        led_num = 5'(nl);
        bit_total = 10'(bt);
        pix_bright = br;
        bit_total_valid = 1'b1;
        tend = (bt >> 5) * (2 + 64 * (s == 1 ? 1 : 2)) + 1;
        words.delete();
        addrs.delete();
        {edges, nb, preq, dones} = '0;
        done_t = -1;
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        t = 0;
        active = 1'b1;
        for (int n = 0; n < 20000 && active; n++) begin
            @(posedge clk) #2;
            start = inject && t == 50;
            if (rst_at > 0 && t == rst_at) begin
                active = 1'b0;
                rst_n = 1'b0;
                #1 chk("async_reset_outputs", int'({busy, frame_done, sclk, sdo, pix_req, pix_addr}), 0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        chk("run_timeout", int'(active), 0);
        active = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        {tests, fails, t, tend, sel, mode} = '0;
        active = 1'b0;
        sclk_p = 1'b0;
        sh = '0;
        rst_n = 1'b1;
        start = 1'b0;
        bit_total_valid = 1'b0;
        led_num = '0;
        bit_total = '0;
        pix_bright = '0;
        fork monitor(); join_none
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 chk("reset_outputs", int'({busy, frame_done, sclk, sdo, pix_req, pix_addr}), 0);
        @(posedge clk) #1 rst_n = 1'b1;

        bit_total = 10'd96;
        led_num = 5'd1;
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("gate_no_valid_busy", int'(busy), 0);

        run(0, 1, 96, 5'h1F, 0, 1'b1, 0);
        chk("three_words", words.size(), 3);
        if (words.size() == 3) begin
            chk("word0", int'(words[0]), 32'h0000_0000);
            chk("word1", int'(words[1]), 32'hFF12_3456);
            chk("word2", int'(words[2]), 32'hFFFF_FFFF);
        end
        chk("sclk_rises", edges, 96);
        chk("done_cycle", done_t, 391);
        chk("one_done_despite_start", dones, 1);

        run(1, 3, 192, 5'h0A, 1, 1'b0, 0);
        chk("fetch_count", preq, 3);
        if (addrs.size() == 3) begin
            chk("addr0", int'(addrs[0]), 0);
            chk("addr1", int'(addrs[1]), 1);
            chk("addr2", int'(addrs[2]), 2);
        end
        chk("six_words", words.size(), 6);
        if (words.size() == 6) begin
            chk("led_word0", int'(words[1]), 32'hEA11_1111);
            chk("led_word1", int'(words[2]), 32'hEA22_2222);
            chk("led_word2", int'(words[3]), 32'hEA33_3333);
            chk("end_word4", int'(words[4]), 32'hFFFF_FFFF);
            chk("end_word5", int'(words[5]), 32'hFFFF_FFFF);
        end
        chk("fetch_done_cycle", done_t, 397);

        run(0, 2, 16, 5'h1F, 0, 1'b0, 0);
        chk("zero_done_cycle", done_t, 1);
        chk("zero_no_sclk", edges, 0);

        run(1, 8, 64, 5'h1F, 1, 1'b0, 0);
        chk("trunc_words", words.size(), 2);
        if (words.size() == 2) begin
            chk("trunc_start", int'(words[0]), 32'h0000_0000);
            chk("trunc_led", int'(words[1]), 32'hFF11_1111);
        end
        chk("trunc_fetch", preq, 1);

        run(0, 1, 96, 5'h1F, 0, 1'b0, 172);
        chk("reset_busy_low", int'(busy), 0);
        run(0, 1, 96, 5'h1F, 0, 1'b0, 0);
        chk("post_reset_words", words.size(), 3);
        if (words.size() == 3) chk("post_reset_led", int'(words[1]), 32'hFF12_3456);
        chk("post_reset_done", done_t, 391);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
